// File: rtl/proc_control.sv
// proc_control: control FSM for the multi-cycle processor.
// Sequences fetch (T0..T2) and execute (T3..T5) over the shared bus.
//
// Ports:
//   Clock, Resetn   - clock and synchronous active-low reset
//   Run             - start/continue fetching, sampled only in T0
//   IR[8:0]         - current instruction {opcode, X, Y}; not latched here
//   G_nz            - G register is non-zero (mvnz condition)
//   Rin, Rout       - one-hot register write enables / bus drive selects
//   Gout, DINout    - G / DIN drive the bus
//   Ain, Gin        - load A from bus / load G from adder
//   AddSub          - 0 = add, 1 = subtract
//   IRin, ADDRin    - load IR from DIN / load ADDR from bus
//   DOUTin, W_D     - load DOUT from bus / memory write enable
//   incr_pc         - R7 increments at the next edge
//   Done            - final step of an instruction
//   Tstep           - current state, for debug
module proc_control (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Run,
  input  logic [8:0] IR,
  input  logic       G_nz,
  output logic [7:0] Rin,
  output logic [7:0] Rout,
  output logic       Gout,
  output logic       DINout,
  output logic       Ain,
  output logic       Gin,
  output logic       AddSub,
  output logic       IRin,
  output logic       ADDRin,
  output logic       DOUTin,
  output logic       W_D,
  output logic       incr_pc,
  output logic       Done,
  output logic [2:0] Tstep
);

  typedef enum logic [2:0] {
    StT0 = 3'd0,
    StT1 = 3'd1,
    StT2 = 3'd2,
    StT3 = 3'd3,
    StT4 = 3'd4,
    StT5 = 3'd5
  } state_e;

  localparam logic [2:0] OpMv   = 3'b000;
  localparam logic [2:0] OpMvi  = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpSub  = 3'b011;
  localparam logic [2:0] OpLd   = 3'b100;
  localparam logic [2:0] OpSt   = 3'b101;
  localparam logic [2:0] OpMvnz = 3'b110;
  localparam logic [2:0] OpUndf = 3'b111;

  state_e     state_q, state_d;
  logic [2:0] opcode;
  logic [7:0] x_oh, y_oh;

  assign opcode = IR[8:6];
  assign x_oh   = 8'd1 << IR[5:3];
  assign y_oh   = 8'd1 << IR[2:0];

  always_comb begin
    state_d = StT0;
    unique case (state_q)
      StT0: state_d = Run ? StT1 : StT0;
      StT1: state_d = StT2;
      StT2: state_d = StT3;
      StT3: begin
        unique case (opcode)
          OpMv, OpMvnz, OpUndf: state_d = StT0;
          default:              state_d = StT4;
        endcase
      end
      StT4: state_d = (opcode == OpSt) ? StT0 : StT5;
      StT5: state_d = StT0;
      default: state_d = StT0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= StT0;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced low for the whole time Resetn is asserted so an
  // aborted instruction cannot write anything in the reset cycle.
  always_comb begin
    Rin     = '0;
    Rout    = '0;
    Gout    = 1'b0;
    DINout  = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    AddSub  = 1'b0;
    IRin    = 1'b0;
    ADDRin  = 1'b0;
    DOUTin  = 1'b0;
    W_D     = 1'b0;
    incr_pc = 1'b0;
    Done    = 1'b0;
    Tstep   = '0;
    if (Resetn) begin
      Tstep = state_q;
      unique case (state_q)
        StT0: begin
          if (Run) begin
            Rout[7] = 1'b1;
            ADDRin  = 1'b1;
          end
        end
        StT1: incr_pc = 1'b1;
        StT2: IRin = 1'b1;
        StT3: begin
          unique case (opcode)
            OpMv: begin
              Rout = y_oh;
              Rin  = x_oh;
              Done = 1'b1;
            end
            OpMvi: begin
              Rout[7] = 1'b1;
              ADDRin  = 1'b1;
            end
            OpAdd, OpSub: begin
              Rout = x_oh;
              Ain  = 1'b1;
            end
            OpLd, OpSt: begin
              Rout   = y_oh;
              ADDRin = 1'b1;
            end
            OpMvnz: begin
              Done = 1'b1;
              if (G_nz) begin
                Rout = y_oh;
                Rin  = x_oh;
              end
            end
            OpUndf: Done = 1'b1;
            default: ;
          endcase
        end
        StT4: begin
          unique case (opcode)
            OpMvi: incr_pc = 1'b1;
            OpAdd, OpSub: begin
              Rout   = y_oh;
              Gin    = 1'b1;
              AddSub = (opcode == OpSub);
            end
            OpSt: begin
              Rout   = x_oh;
              DOUTin = 1'b1;
              W_D    = 1'b1;
              Done   = 1'b1;
            end
            default: ;
          endcase
        end
        StT5: begin
          unique case (opcode)
            OpMvi, OpLd: begin
              DINout = 1'b1;
              Rin    = x_oh;
              Done   = 1'b1;
            end
            OpAdd, OpSub: begin
              Gout = 1'b1;
              Rin  = x_oh;
              Done = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_control.sv
module tb_proc_control;

  logic       Clock = 1'b0;
  logic       Resetn, Run, G_nz;
  logic [8:0] IR;
  logic [7:0] Rin, Rout;
  logic       Gout, DINout, Ain, Gin, AddSub, IRin, ADDRin, DOUTin, W_D, incr_pc, Done;
  logic [2:0] Tstep;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        mon_en   = 1'b0;

  // Flag bit positions inside the packed expected-output word.
  localparam logic [10:0] FG    = 11'h400;
  localparam logic [10:0] FDin  = 11'h200;
  localparam logic [10:0] FA    = 11'h100;
  localparam logic [10:0] FGin  = 11'h080;
  localparam logic [10:0] FSub  = 11'h040;
  localparam logic [10:0] FIr   = 11'h020;
  localparam logic [10:0] FAddr = 11'h010;
  localparam logic [10:0] FDout = 11'h008;
  localparam logic [10:0] FWd   = 11'h004;
  localparam logic [10:0] FInc  = 11'h002;
  localparam logic [10:0] FDone = 11'h001;

  proc_control dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Run     (Run),
    .IR      (IR),
    .G_nz    (G_nz),
    .Rin     (Rin),
    .Rout    (Rout),
    .Gout    (Gout),
    .DINout  (DINout),
    .Ain     (Ain),
    .Gin     (Gin),
    .AddSub  (AddSub),
    .IRin    (IRin),
    .ADDRin  (ADDRin),
    .DOUTin  (DOUTin),
    .W_D     (W_D),
    .incr_pc (incr_pc),
    .Done    (Done),
    .Tstep   (Tstep)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] ev(input logic [7:0] rin, input logic [7:0] rout,
                                     input logic [10:0] flags, input logic [2:0] t);
    return {rin, rout, flags, t};
  endfunction

  function automatic logic [29:0] observed();
    return {Rin, Rout, Gout, DINout, Ain, Gin, AddSub, IRin, ADDRin, DOUTin, W_D,
            incr_pc, Done, Tstep};
  endfunction

  // Check the current cycle's outputs, then advance one clock.
  task automatic cycle(input string tag, input logic [29:0] exp);
    #1;
    check(tag, {2'b0, observed()}, {2'b0, exp});
    @(posedge Clock);
    #1;
  endtask

  task automatic fetch(input logic [8:0] ir, input logic run_after);
    Run = 1'b1;
    IR  = ir;
    cycle("t0_fetch", ev(8'h00, 8'h80, FAddr, 3'd0));
    Run = run_after;
    cycle("t1_incr", ev(8'h00, 8'h00, FInc, 3'd1));
    cycle("t2_irin", ev(8'h00, 8'h00, FIr, 3'd2));
  endtask

  // Structural invariants sampled mid-cycle.
  always @(negedge Clock) begin
    if (mon_en) begin
      check("bus_excl", {31'b0, $countones({Rout, Gout, DINout}) <= 1}, 32'd1);
      check("rin_onehot0", {31'b0, $countones(Rin) <= 1}, 32'd1);
    end
  end

  initial begin
    Resetn = 1'b0;
    Run    = 1'b0;
    G_nz   = 1'b0;
    IR     = '0;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    check("reset_outputs", {2'b0, observed()}, {2'b0, ev(8'h00, 8'h00, 11'h0, 3'd0)});
    Resetn = 1'b1;
    mon_en = 1'b1;

    // Idle in T0 while Run is low.
    for (int i = 0; i < 5; i++) cycle("idle_t0", ev(8'h00, 8'h00, 11'h0, 3'd0));

    // mvi R3
    fetch(9'b001_011_000, 1'b1);
    cycle("mvi_t3", ev(8'h00, 8'h80, FAddr, 3'd3));
    cycle("mvi_t4", ev(8'h00, 8'h00, FInc, 3'd4));
    cycle("mvi_t5", ev(8'h08, 8'h00, FDin | FDone, 3'd5));

    // sub R1,R2 back-to-back
    fetch(9'b011_001_010, 1'b1);
    cycle("sub_t3", ev(8'h00, 8'h02, FA, 3'd3));
    cycle("sub_t4", ev(8'h00, 8'h04, FGin | FSub, 3'd4));
    cycle("sub_t5", ev(8'h02, 8'h00, FG | FDone, 3'd5));

    // add R4,R0
    fetch(9'b010_100_000, 1'b1);
    cycle("add_t3", ev(8'h00, 8'h10, FA, 3'd3));
    cycle("add_t4", ev(8'h00, 8'h01, FGin, 3'd4));
    cycle("add_t5", ev(8'h10, 8'h00, FG | FDone, 3'd5));

    // st R5 -> [R6]
    fetch(9'b101_101_110, 1'b1);
    cycle("st_t3", ev(8'h00, 8'h40, FAddr, 3'd3));
    cycle("st_t4", ev(8'h00, 8'h20, FDout | FWd | FDone, 3'd4));

    // ld R6 <- [R1]
    fetch(9'b100_110_001, 1'b1);
    cycle("ld_t3", ev(8'h00, 8'h02, FAddr, 3'd3));
    cycle("ld_t4", ev(8'h00, 8'h00, 11'h0, 3'd4));
    cycle("ld_t5", ev(8'h40, 8'h00, FDin | FDone, 3'd5));

    // mv R2,R5
    fetch(9'b000_010_101, 1'b1);
    cycle("mv_t3", ev(8'h04, 8'h20, FDone, 3'd3));

    // mv R7,R0 (PC write)
    fetch(9'b000_111_000, 1'b1);
    cycle("mv_pc_t3", ev(8'h80, 8'h01, FDone, 3'd3));

    // mvnz R0,R4 not taken then taken
    G_nz = 1'b0;
    fetch(9'b110_000_100, 1'b1);
    cycle("mvnz0_t3", ev(8'h00, 8'h00, FDone, 3'd3));
    G_nz = 1'b1;
    fetch(9'b110_000_100, 1'b1);
    cycle("mvnz1_t3", ev(8'h01, 8'h10, FDone, 3'd3));
    G_nz = 1'b0;

    // Undefined opcode; Run dropped after T0 must not stop it
    fetch(9'b111_011_010, 1'b0);
    cycle("undef_t3", ev(8'h00, 8'h00, FDone, 3'd3));
    cycle("stop_t0", ev(8'h00, 8'h00, 11'h0, 3'd0));
    cycle("stop_t0b", ev(8'h00, 8'h00, 11'h0, 3'd0));

    // Reset during T4 of add aborts it
    fetch(9'b010_001_010, 1'b1);
    cycle("addr_t3", ev(8'h00, 8'h02, FA, 3'd3));
    Resetn = 1'b0;
    cycle("rst_in_t4", ev(8'h00, 8'h00, 11'h0, 3'd0));
    cycle("rst_hold", ev(8'h00, 8'h00, 11'h0, 3'd0));
    Resetn = 1'b1;
    Run    = 1'b0;
    cycle("rst_rel_t0", ev(8'h00, 8'h00, 11'h0, 3'd0));
    fetch(9'b000_001_010, 1'b1);
    cycle("post_rst_mv", ev(8'h02, 8'h04, FDone, 3'd3));

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
